fragment_video_packer: RTL and testbench

- Downstream neighbour of the coprocessor. Consumes its 32-bit AXIS fragment stream, one packed RGB pixel per beat, with TLAST on the final pixel of the frame.
- Re-emits the pixels as an AXI4-Stream video stream to the VDMA / display path:
  - 24-bit RGB data;
  - TUSER marks start-of-frame;
  - TLAST marks end-of-line.
- Contains an internal FIFO that absorbs downstream back-pressure so the render core is stalled as little as possible.

---
 rtl/raytracer_pkg.sv | 31 +++
 rtl/axis_fifo_sync.sv | 48 ++++
 rtl/fragment_video_packer.sv | 131 +++++++++++++
 tb/tb_fragment_video_packer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raytracer_pkg.sv
// Shared types for the raytracer output path: fragment field layout, pixel type,
// packer FSM states and the tagged video beat carried through the pixel FIFO.
package raytracer_pkg;

    localparam int unsigned FRAG_R_MSB = 23;
    localparam int unsigned FRAG_R_LSB = 16;
    localparam int unsigned FRAG_G_MSB = 15;
    localparam int unsigned FRAG_G_LSB = 8;
    localparam int unsigned FRAG_B_MSB = 7;
    localparam int unsigned FRAG_B_LSB = 0;

    typedef logic [23:0] rgb24;

    typedef enum logic [1:0] {
        PK_IDLE   = 2'd0,
        PK_STREAM = 2'd1,
        PK_DRAIN  = 2'd2
    } packer_state_e;

    typedef struct packed {
        logic tuser;
        logic tlast;
        rgb24 rgb;
    } vid_beat_t;

    // The top byte of a fragment is padding and is dropped here.
    function automatic rgb24 frag_to_rgb(input logic [31:0] frag);
        return {frag[FRAG_R_MSB:FRAG_R_LSB], frag[FRAG_G_MSB:FRAG_G_LSB], frag[FRAG_B_MSB:FRAG_B_LSB]};
    endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on m_data
// while m_valid is high. DEPTH must be a power of two, at least 2.
module axis_fifo_sync #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             full,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push;
    logic             pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign m_valid = !empty;
    assign m_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign push    = s_valid && !full;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end

endmodule

// File: rtl/fragment_video_packer.sv
// Repacks the 32-bit fragment stream into 24-bit AXI4-Stream video (TUSER=SOF,
// TLAST=EOL) through a pixel FIFO. Framing checks enabled by PACKER_FRAME_CHECK_EN.
module fragment_video_packer
    import raytracer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIM_W      = 16
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic [DIM_W-1:0] cfg_image_width,
    input  logic [DIM_W-1:0] cfg_image_height,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [23:0]      m_axis_tdata,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             frame_err
);

    packer_state_e    state_q;
    logic             run_q;
    logic [DIM_W-1:0] width_q;
    logic [DIM_W-1:0] col_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             take_ok;
    logic             accept;
    logic             first_beat;
    logic [DIM_W-1:0] eff_width;
    logic [DIM_W-1:0] eff_col;
    logic             col_last;
    logic             beat_tlast;
    logic             frame_end;
    vid_beat_t        wr_beat;
    vid_beat_t        rd_beat;

    // The first beat of a frame is tagged using the live cfg values, since the
    // latch into width_q/height_q happens on that same edge.
    assign first_beat = (state_q == PK_IDLE);
    assign eff_width  = first_beat ? cfg_image_width : width_q;
    assign eff_col    = first_beat ? '0 : col_q;
    assign col_last   = (eff_col == eff_width - DIM_W'(1));

`ifdef PACKER_FRAME_CHECK_EN
    logic [DIM_W-1:0] height_q;
    logic [DIM_W-1:0] row_q;
    logic             frame_err_q;
    logic [DIM_W-1:0] eff_height;
    logic [DIM_W-1:0] eff_row;
    logic             frame_full;

    assign eff_height = first_beat ? cfg_image_height : height_q;
    assign eff_row    = first_beat ? '0 : row_q;
    assign frame_full = col_last && (eff_row == eff_height - DIM_W'(1));
    assign beat_tlast = col_last || s_axis_tlast;
    assign frame_end  = s_axis_tlast || frame_full;
    assign frame_err  = frame_err_q;
`else
    assign beat_tlast = col_last;
    assign frame_end  = s_axis_tlast;
    assign frame_err  = 1'b0;
`endif

    always_comb begin
        take_ok = 1'b0;
        case (state_q)
            PK_IDLE:   take_ok = run_q && (|cfg_image_width) && (|cfg_image_height) && !fifo_full;
            PK_STREAM: take_ok = !fifo_full;
            default:   take_ok = 1'b0;
        endcase
    end

    assign s_axis_tready = take_ok;
    assign accept        = s_axis_tvalid && take_ok;
    assign wr_beat       = '{tuser: first_beat, tlast: beat_tlast, rgb: frag_to_rgb(s_axis_tdata)};

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= PK_IDLE;
            run_q       <= 1'b0;
            width_q     <= '0;
            col_q       <= '0;
`ifdef PACKER_FRAME_CHECK_EN
            height_q    <= '0;
            row_q       <= '0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                if (first_beat) width_q <= cfg_image_width;
                col_q   <= col_last ? '0 : eff_col + DIM_W'(1);
                state_q <= frame_end ? PK_DRAIN : PK_STREAM;
`ifdef PACKER_FRAME_CHECK_EN
                if (first_beat) height_q <= cfg_image_height;
                row_q <= col_last ? eff_row + DIM_W'(1) : eff_row;
                if (s_axis_tlast != frame_full) frame_err_q <= 1'b1;
`endif
            end else if (state_q == PK_DRAIN && fifo_empty) begin
                state_q <= PK_IDLE;
            end
        end
    end

    axis_fifo_sync #(
        .WIDTH ($bits(vid_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (resetn),
        .s_valid (accept),
        .s_data  (wr_beat),
        .full    (fifo_full),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (rd_beat),
        .empty   (fifo_empty)
    );

    assign m_axis_tdata = rd_beat.rgb;
    assign m_axis_tuser = rd_beat.tuser;
    assign m_axis_tlast = rd_beat.tlast;
    assign busy         = (state_q != PK_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fragment_video_packer.sv
// Bench for fragment_video_packer: table-driven frames, hand-written reset and
// zero-width sequences, and random frames checked against a queue-based model.
module tb_fragment_video_packer;

    logic        aclk = 1'b0;
    logic        resetn;
    logic [15:0] cfg_w;
    logic [15:0] cfg_h;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;
    logic        m_user;
    logic        m_last;
    logic        busy;
    logic        frame_err;

    fragment_video_packer #(
        .FIFO_DEPTH (16),
        .DIM_W      (16)
    ) dut (
        .aclk             (aclk),
        .resetn           (resetn),
        .cfg_image_width  (cfg_w),
        .cfg_image_height (cfg_h),
        .s_axis_tvalid    (s_valid),
        .s_axis_tready    (s_ready),
        .s_axis_tdata     (s_data),
        .s_axis_tlast     (s_last),
        .m_axis_tvalid    (m_valid),
        .m_axis_tready    (m_ready),
        .m_axis_tdata     (m_data),
        .m_axis_tuser     (m_user),
        .m_axis_tlast     (m_last),
        .busy             (busy),
        .frame_err        (frame_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [23:0] rgb;
        logic        tuser;
        logic        tlast;
    } beat_t;

    typedef struct {
        int          w;
        int          h;
        int          n;
        int          last_idx;
        logic [31:0] base;
        int          stall;
        bit          chk_busy;
        int          exp_beats;
        int          exp_tl;
        bit          exp_ferr;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    beat_t       exp_q[$];
    bit          exp_err = 1'b0;
    int          beat_cnt = 0;
    int          tl_cnt = 0;
    int          rdy_mode = 0;
    logic [31:0] frag_buf [64];
    bit          hold_v = 1'b0;
    beat_t       hold_b;
    beat_t       got_b;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Output monitor: sampled on the falling edge, handshakes land on the next rising edge.
    always @(negedge aclk) begin
        if (!resetn) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("hold_stable", {5'd0, m_valid, m_user, m_last, m_data},
                      {5'd0, 1'b1, hold_b.tuser, hold_b.tlast, hold_b.rgb});
            hold_v = m_valid && !m_ready;
            hold_b = '{rgb: m_data, tuser: m_user, tlast: m_last};
            if (m_valid && m_ready) begin
                beat_cnt++;
                tl_cnt += int'(m_last);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    got_b = exp_q.pop_front();
                    check("beat", {6'd0, m_user, m_last, m_data}, {6'd0, got_b.tuser, got_b.tlast, got_b.rgb});
                end
            end
        end
    end

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Reference: pixel i of a frame sits at column i mod w; the frame ends on
    // the tlast fragment (or, with framing checks, at pixel w*h).
    task automatic model_frame(input int w, input int h, input int n, input int last_idx, output int n_acc);
        bit done = 1'b0;
        n_acc = n;
        for (int i = 0; i < n && !done; i++) begin
            beat_t b;
            bit    lastin;
            lastin  = (i == last_idx);
            b.rgb   = frag_buf[i][23:0];
            b.tuser = (i == 0);
            b.tlast = ((i % w) == w - 1);
`ifdef PACKER_FRAME_CHECK_EN
            if (lastin && i != w * h - 1) begin
                exp_err = 1'b1;
                b.tlast = 1'b1;
            end
            if (!lastin && i == w * h - 1) begin
                exp_err = 1'b1;
                done    = 1'b1;
                n_acc   = i + 1;
            end
`else
            if (h < 0) done = 1'b1;
`endif
            exp_q.push_back(b);
            if (lastin) begin
                done  = 1'b1;
                n_acc = i + 1;
            end
        end
    endtask

    task automatic run_frame(input int w, input int h, input int n, input int last_idx,
                             input logic [31:0] base, input bit rnd, input int stall,
                             input bit rcfg, input bit chk_busy,
                             output int beats, output int tls, output int first_acc, output int n_acc);
        int i;
        int cyc;
        int saved;
        for (int k = 0; k < n; k++) frag_buf[k] = rnd ? $urandom : base + 32'(k);
        model_frame(w, h, n, last_idx, n_acc);
        beat_cnt  = 0;
        tl_cnt    = 0;
        cfg_w     = 16'(w);
        cfg_h     = 16'(h);
        saved     = rdy_mode;
        if (stall > 0) rdy_mode = 2;
        i         = 0;
        cyc       = 0;
        first_acc = -1;
        while (i < n_acc && cyc < 2000) begin
            s_valid = 1'b1;
            s_data  = frag_buf[i];
            s_last  = (i == last_idx);
            @(negedge aclk);
            if (stall > 0 && cyc == stall) begin
                check("stall_accepts", 32'(i), 32'd16);
                check("stall_tready", {31'd0, s_ready}, 32'd0);
                rdy_mode = saved;
            end
            if (s_ready) begin
                if (first_acc < 0) first_acc = cyc;
                i++;
            end
            cyc++;
            @(posedge aclk);
            #1;
            if (rcfg && i > 0) begin
                cfg_w = 16'($urandom_range(0, 9));
                cfg_h = 16'($urandom_range(0, 9));
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("accept_count", 32'(i), 32'(n_acc));
        if (chk_busy) begin
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 500) begin
                @(posedge aclk);
                #1;
                cyc++;
            end
            @(negedge aclk);
            check("busy_1_after_last", {31'd0, busy}, 32'd1);
            @(posedge aclk);
            #1;
            @(negedge aclk);
            check("busy_2_after_last", {31'd0, busy}, 32'd0);
        end
        cyc = 0;
        while ((busy || exp_q.size() != 0) && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_missing_beats", 32'(exp_q.size()), 32'd0);
        check("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
        beats = beat_cnt;
        tls   = tl_cnt;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        int   beats;
        int   tls;
        int   fa;
        int   nacc;
        int   acc;
        int   cyc;
        bit   chk_en;

`ifdef PACKER_FRAME_CHECK_EN
        chk_en = 1'b1;
`else
        chk_en = 1'b0;
`endif
        vt[0] = '{w: 4, h: 2, n: 8,  last_idx: 7,  base: 32'h0000_0001, stall: 0,  chk_busy: 1, exp_beats: 8,  exp_tl: 2, exp_ferr: 0};
        vt[1] = '{w: 4, h: 8, n: 32, last_idx: 31, base: 32'h0010_2030, stall: 20, chk_busy: 0, exp_beats: 32, exp_tl: 8, exp_ferr: 0};
        vt[2] = '{w: 1, h: 1, n: 1,  last_idx: 0,  base: 32'hFFAA_BBCC, stall: 0,  chk_busy: 0, exp_beats: 1,  exp_tl: 1, exp_ferr: 0};
        vt[3] = '{w: 4, h: 2, n: 8,  last_idx: 5,  base: 32'h0000_0040, stall: 0,  chk_busy: 0, exp_beats: 6,
                  exp_tl: chk_en ? 2 : 1, exp_ferr: chk_en};
        vt[4] = '{w: 4, h: 2, n: 8,  last_idx: 7,  base: 32'h0000_0080, stall: 0,  chk_busy: 0, exp_beats: 8,  exp_tl: 2, exp_ferr: chk_en};

        resetn  = 1'b0;
        cfg_w   = '0;
        cfg_h   = '0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_out", {6'd0, m_user, m_last, m_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        @(posedge aclk);
        #1;
        resetn = 1'b1;
        @(posedge aclk);
        #1;

        for (int k = 0; k < 5; k++) begin
            rdy_mode = 0;
            run_frame(vt[k].w, vt[k].h, vt[k].n, vt[k].last_idx, vt[k].base, 1'b0, vt[k].stall,
                      1'b0, vt[k].chk_busy, beats, tls, fa, nacc);
            check($sformatf("vec%0d_beats", k), 32'(beats), 32'(vt[k].exp_beats));
            check($sformatf("vec%0d_tlasts", k), 32'(tls), 32'(vt[k].exp_tl));
            check($sformatf("vec%0d_ferr", k), {31'd0, frame_err}, {31'd0, vt[k].exp_ferr});
        end

        // Reset in the middle of a frame with three pixels parked in the FIFO.
        rdy_mode = 2;
        cfg_w    = 16'd4;
        cfg_h    = 16'd2;
        acc      = 0;
        cyc      = 0;
        @(posedge aclk);
        #1;
        while (acc < 3 && cyc < 50) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            s_last  = 1'b0;
            @(negedge aclk);
            if (s_ready) acc++;
            cyc++;
            @(posedge aclk);
            #1;
        end
        s_valid = 1'b0;
        check("midframe_accepts", 32'(acc), 32'd3);
        check("midframe_m_valid", {31'd0, m_valid}, 32'd1);
        resetn  = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        @(negedge aclk);
        check("inrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("inrst_s_ready", {31'd0, s_ready}, 32'd0);
        check("inrst_busy", {31'd0, busy}, 32'd0);
        check("inrst_frame_err", {31'd0, frame_err}, 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        resetn   = 1'b1;
        rdy_mode = 0;
        @(posedge aclk);
        #1;
        run_frame(4, 2, 8, 7, 32'h0000_0100, 1'b0, 0, 1'b0, 1'b0, beats, tls, fa, nacc);
        check("postrst_beats", 32'(beats), 32'd8);
        check("postrst_tlasts", 32'(tls), 32'd2);

        // Zero width blocks acceptance; a legal width is accepted immediately.
        cfg_w   = 16'd0;
        cfg_h   = 16'd2;
        s_valid = 1'b1;
        s_data  = 32'h0000_0055;
        s_last  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("zero_w_tready", {31'd0, s_ready}, 32'd0);
            check("zero_w_m_valid", {31'd0, m_valid}, 32'd0);
            @(posedge aclk);
            #1;
        end
        run_frame(2, 2, 4, 3, 32'h0000_0200, 1'b0, 0, 1'b0, 1'b0, beats, tls, fa, nacc);
        check("zero_w_first_accept_cycle", 32'(fa), 32'd0);
        check("zero_w_beats", 32'(beats), 32'd4);
        check("zero_w_tlasts", 32'(tls), 32'd2);

        // Random frames, random back-pressure, cfg scrambled mid-frame.
        rdy_mode = 1;
        for (int k = 0; k < 25; k++) begin
            int w;
            int h;
            int li;
            w  = int'($urandom_range(1, 5));
            h  = int'($urandom_range(1, 4));
            li = int'($urandom_range(0, 32'(w * h + 2)));
            run_frame(w, h, li + 1, li, 32'd0, 1'b1, 0, 1'b1, 1'b0, beats, tls, fa, nacc);
            check("rand_beats", 32'(beats), 32'(nacc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
